// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one CHUNK-bit carry-lookahead slice,
// consuming one chunk per clock behind valid/ready handshakes.
module cla_seq_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [CHUNK-1:0]  a_chunk, b_chunk, p, g, slice_sum;
  logic [CHUNK:0]    c;

  // Group carry equations: c[i+1] = OR_j (g[j] & p[j+1..i]) | (p[0..i] & c0)
  function automatic logic [CHUNK:0] clu(input logic [CHUNK-1:0] pp,
                                         input logic [CHUNK-1:0] gg,
                                         input logic             c0);
    logic [CHUNK:0] cc;
    logic           term;
    cc    = '0;
    cc[0] = c0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      term = c0;
      for (int k = 0; k <= i; k++) term = term & pp[k];
      cc[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = gg[j];
        for (int k = j + 1; k <= i; k++) term = term & pp[k];
        cc[i+1] = cc[i+1] | term;
      end
    end
    return cc;
  endfunction

  // Lookahead slice on the current chunk
  always_comb begin
    a_chunk   = a_q[32'(idx_q)*CHUNK +: CHUNK];
    b_chunk   = b_q[32'(idx_q)*CHUNK +: CHUNK];
    p         = a_chunk ^ b_chunk;
    g         = a_chunk & b_chunk;
    c         = clu(p, g, carry_q);
    slice_sum = p ^ c[CHUNK-1:0];
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[32'(idx_q)*CHUNK +: CHUNK] = slice_sum;
        carry_d = c[CHUNK];
        if (idx_q == IDXW'(NCHUNK - 1)) begin
          cout_d  = c[CHUNK];
          ovf_d   = c[CHUNK-1] ^ c[CHUNK];
          state_d = DONE;
        end else begin
          idx_d = IDXW'(idx_q + 1'b1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: vector table, handshake corner cases and a CHUNK sweep.
module tb_cla_seq_adder;

  localparam int unsigned NCH = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    res_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        sw_rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [31:0] a, b, sum;

  int   cyc = 0;
  int   acc_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  res_t sbq[$];

  cla_seq_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] s;
    res_t        r;
    s      = {1'b0, x} + {1'b0, y} + 33'(c);
    r.sum  = s[31:0];
    r.cout = s[32];
    r.ovf  = (x[31] == y[31]) && (s[31] != x[31]);
    return r;
  endfunction

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ic, input res_t e);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk1("issue_ready", in_ready, 1'b1);
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    sbq.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic await_out(input string tag);
    int   n;
    res_t e;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk32({tag, "_latency"}, 32'(cyc - acc_cyc), NCH);
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard: got result with empty queue required pending entry", tag);
    end else begin
      e = sbq.pop_front();
      chk32({tag, "_sum"}, sum, e.sum);
      chk1({tag, "_cout"}, cout, e.cout);
      chk1({tag, "_ovf"}, ovf, e.ovf);
    end
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1({tag, "_take_valid"}, out_valid, 1'b0);
    chk1({tag, "_take_ready"}, in_ready, 1'b1);
  endtask

  // CHUNK sweep: independent instances running random operands concurrently
  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int unsigned CH = (gi == 0) ? 1 : ((gi == 1) ? 4 : 32);
    localparam int unsigned NC = 32 / CH;
    logic        iv, ir, ov, orr, ci, co, ovv, bz, done;
    logic [31:0] sa, sb, ss;
    res_t        q[$];

    cla_seq_adder #(.WIDTH(32), .CHUNK(CH)) u_sw (
      .clk(clk), .rst_n(sw_rst_n), .in_valid(iv), .in_ready(ir),
      .a(sa), .b(sb), .cin(ci), .out_valid(ov), .out_ready(orr),
      .sum(ss), .cout(co), .ovf(ovv), .busy(bz)
    );

    initial begin
      int          acc, n;
      res_t        e;
      logic [31:0] ra, rb;
      logic        rc;
      done = 1'b0; iv = 1'b0; orr = 1'b1; sa = '0; sb = '0; ci = 1'b0;
      wait (sw_rst_n === 1'b1);
      @(posedge clk); #1;
      for (int t = 0; t < 1000; t++) begin
        n = 0;
        while (!ir && n < 100) begin @(posedge clk); #1; n++; end
        chk1("sweep_ready", ir, 1'b1);
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
        if (t == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0; rc = 1'b1; end
        if (t == 1) begin ra = 32'h7FFF_FFFF; rb = 32'h7FFF_FFFF; rc = 1'b1; end
        sa = ra; sb = rb; ci = rc; iv = 1'b1;
        @(posedge clk); #1;
        acc = cyc; iv = 1'b0;
        q.push_back(ref_add(ra, rb, rc));
        n = 0;
        while (!ov && n < 100) begin @(posedge clk); #1; n++; end
        chk32("sweep_latency", 32'(cyc - acc), NC);
        e = q.pop_front();
        chk32("sweep_sum", ss, e.sum);
        chk1("sweep_cout", co, e.cout);
        chk1("sweep_ovf", ovv, e.ovf);
        @(posedge clk); #1;
      end
      done = 1'b1;
    end
  end

  initial begin
    vec_t        vt[7];
    int          accs[3];
    int          n;
    logic [31:0] ba[3], bb[3];
    logic        bc[3];

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}};
    vt[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}};
    vt[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, 1'b1}};
    vt[3] = '{32'h1234_5678, 32'h1111_1111, 1'b1, '{32'h2345_678A, 1'b0, 1'b0}};
    vt[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, '{32'h0000_0001, 1'b0, 1'b0}};
    vt[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0}};
    vt[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, '{32'h0100_0100, 1'b0, 1'b0}};

    rst_n = 1'b0; sw_rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_sum", sum, 32'h0);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; sw_rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      issue(vt[i].a, vt[i].b, vt[i].cin, vt[i].exp);
      await_out("vec");
      take("vec");
    end

    // Backpressure: result held while new operands are offered
    issue(32'h1234_5678, 32'h1111_1111, 1'b1, '{32'h2345_678A, 1'b0, 1'b0});
    await_out("bp");
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      chk1("bp_out_valid", out_valid, 1'b1);
      chk32("bp_sum", sum, 32'h2345_678A);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1("bp_no_overlap_busy", busy, 1'b0);
    chk1("bp_no_overlap_valid", out_valid, 1'b0);
    in_valid = 1'b0;

    // Reset during the second RUN cycle
    issue(32'h0101_0101, 32'h0101_0101, 1'b0, ref_add(32'h0101_0101, 32'h0101_0101, 1'b0));
    @(posedge clk); #1;
    chk1("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk32("mid_rst_sum", sum, 32'h0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_cout", cout, 1'b0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("mid_rel_ready", in_ready, 1'b1);
    issue(32'd5, 32'd7, 1'b0, '{32'd12, 1'b0, 1'b0});
    await_out("post_rst");
    take("post_rst");

    // Back-to-back with both handshakes held high
    ba[0] = 32'hDEAD_BEEF; bb[0] = 32'h2152_4111; bc[0] = 1'b1;
    ba[1] = 32'h8000_0001; bb[1] = 32'hFFFF_FFFF; bc[1] = 1'b0;
    ba[2] = 32'h4000_0000; bb[2] = 32'h4000_0000; bc[2] = 1'b0;
    out_ready = 1'b1;
    a = ba[0]; b = bb[0]; cin = bc[0]; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      acc_cyc = cyc;
      accs[k] = cyc;
      sbq.push_back(ref_add(ba[k], bb[k], bc[k]));
      if (k > 0) chk32("b2b_spacing", 32'(accs[k] - accs[k-1]), 32'd6);
      if (k < 2) begin a = ba[k+1]; b = bb[k+1]; cin = bc[k+1]; end
      else in_valid = 1'b0;
      await_out("b2b");
      @(posedge clk); #1;
      chk1("b2b_idle_ready", in_ready, 1'b1);
    end
    out_ready = 1'b0;

    n = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && n < 80000) begin
      @(posedge clk); n++;
    end
    chk1("sweep_done", g_sw[0].done && g_sw[1].done && g_sw[2].done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle wide adder controller. It computes a WIDTH-bit add with a single CHUNK-bit carry-lookahead slice, processing one chunk per clock.
- The chunk carry is held in a register between cycles.
- Valid/ready handshakes on both input and output let it sit between pipeline stages where area matters more than latency.
- The internal slice is a CHUNK-bit lookahead built from per-bit p = a^b and g = a&b, using the team's clu group carry equations.

Parameters:
- WIDTH, 32: operand/sum width. Must be an integer multiple of CHUNK.
- CHUNK, 8: bits added per cycle, i.e. the lookahead slice width. Legal values 1..WIDTH.
- NCHUNK, WIDTH/CHUNK: derived, localparam. Number of RUN cycles.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to bit 0
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  a+b+cin, low WIDTH bits
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; idx, carry, sum, cout, ovf = 0.
  - out_valid = 0, in_ready = 1, busy = 0.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state == IDLE), combinational from state only.
  - out_valid = (state == DONE), registered.
- IDLE:
  - On an edge with in_valid & in_ready: latch a, b; carry <= cin; idx <= 0; go to RUN.
  - sum/cout/ovf keep their previous values until overwritten.
- RUN, each cycle:
  - Slice adds a[idx*CHUNK +: CHUNK] + b[same] + carry.
  - At the edge: write the chunk result into sum[idx*CHUNK +: CHUNK]; carry <= slice carry-out; idx <= idx+1.
  - When idx == NCHUNK-1 at the edge: cout <= slice carry-out; ovf <= carry into chunk MSB XOR slice carry-out; go to DONE.
  - a, b, cin, in_valid are ignored in RUN and DONE.
- DONE:
  - sum, cout, ovf are held stable while out_ready = 0, for any number of cycles.
  - On an edge with out_ready = 1: go to IDLE.
  - No new operand is accepted in the same edge; there is no overlap.
- Latency: out_valid is first high exactly NCHUNK cycles after the accepting edge.
- Throughput: with out_ready and in_valid held at 1, accepting edges are NCHUNK+2 cycles apart.
- CHUNK == WIDTH: single RUN cycle; latency 1.
- Carry chain: the carry into chunk k equals the carry out of chunk k-1, with the carry into chunk 0 = cin. The result must be bit-exact to a full WIDTH-bit add.
- Reset mid-RUN or mid-DONE:
  - The pending operation is discarded, not completed.
  - Outputs return to reset values immediately.
  - After rst_n release, in_ready = 1 on the first cycle.
- idx is sized clog2(NCHUNK) bits, minimum 1. It never exceeds NCHUNK-1; no wrap is needed.
- X-safety: out_valid and in_ready must never be X after reset. sum may be X-free-initialised only via reset.

Test Plan (WIDTH=32, CHUNK=8 unless noted):
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 cycles out_valid=1, sum=0x00000000, cout=1, ovf=0. The carry ripples through all 4 chunks.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Backpressure: after completing 0x12345678 + 0x11111111 with cin=1, hold out_ready=0 for 5 cycles.
  - Required: out_valid stays 1, sum stays 0x2345678A, in_ready=0.
  - in_valid pulses with new operands in these cycles must be ignored.
- Reset mid-operation: drop rst_n during the 2nd RUN cycle.
  - Required: out_valid=0, sum=0, busy=0 immediately.
  - After release, in_ready=1, and a fresh 5+7 add yields sum=12 after 4 cycles.
- Back-to-back: out_ready=1 and in_valid=1 constantly for 3 operations.
  - Required: accepting edges are 6 cycles apart, and each result matches the reference model.
- Parameter sweep: CHUNK in {1, 4, 32} with WIDTH=32, 1000 random operands plus cin each.
  - Required: {cout,sum} == a+b+cin, ovf matches the signed model, latency == NCHUNK in every case.
